// File: rtl/pipe_pkg.sv
// Shared types and default widths for the skid-buffered pipeline stage.
package pipe_pkg;

   localparam int unsigned PIPE_DATA_W = 32;
   localparam int unsigned PIPE_CTRL_W = 12;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } pipe_state_t;

   // Number of entries held in a given state.
   function automatic logic [1:0] state_occupancy(input pipe_state_t s);
      logic [1:0] occ;
      case (s)
         BUSY:    occ = 2'd1;
         FULL:    occ = 2'd2;
         default: occ = 2'd0;
      endcase
      return occ;
   endfunction

endpackage

// File: rtl/pipe_skid_ctrl.sv
// Control FSM for pipe_stage_skid: state, in_ready, out_valid, occupancy and the
// register load enables for the main/skid registers held by the parent.
// PIPE_STAGE_SKID_EN selects the 2-entry variant with a registered in_ready;
// without it the stage is a single register with a combinational in_ready.
module pipe_skid_ctrl
   import pipe_pkg::*;
(
   input  logic       CLK,
   input  logic       RST,
   input  logic       i_flush,
   input  logic       i_in_valid,
   input  logic       i_out_ready,
   output logic       o_in_ready,
   output logic       o_out_valid,
   output logic [1:0] o_occupancy,
   output logic       o_ld_main,
   output logic       o_sel_skid,
   output logic       o_ld_skid,
   output logic       o_kill
);

   pipe_state_t r_state;
   pipe_state_t w_state_d;
   logic        r_out_valid;
   logic [1:0]  r_occupancy;
   logic        w_in_ready;
   logic        w_in_xfer;
   logic        w_out_xfer;

`ifdef PIPE_STAGE_SKID_EN
   logic r_in_ready;
   assign w_in_ready = r_in_ready;
`else
   // Single register: a slot frees up in the same cycle the consumer takes it.
   assign w_in_ready = !r_out_valid || i_out_ready;
`endif

   assign w_in_xfer  = i_in_valid && w_in_ready;
   assign w_out_xfer = r_out_valid && i_out_ready;

   // Next state and register load enables; flush overrides every transfer.
   always_comb begin
      w_state_d  = r_state;
      o_ld_main  = 1'b0;
      o_sel_skid = 1'b0;
      o_ld_skid  = 1'b0;
      o_kill     = 1'b0;
      unique case (r_state)
         EMPTY: begin
            if (w_in_xfer) begin
               w_state_d = BUSY;
               o_ld_main = 1'b1;
            end
         end
         BUSY: begin
            if (w_in_xfer && w_out_xfer) begin
               o_ld_main = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
            end else if (w_in_xfer) begin
               w_state_d = FULL;
               o_ld_skid = 1'b1;
`endif
            end else if (w_out_xfer) begin
               w_state_d = EMPTY;
            end
         end
`ifdef PIPE_STAGE_SKID_EN
         FULL: begin
            if (w_out_xfer) begin
               w_state_d  = BUSY;
               o_ld_main  = 1'b1;
               o_sel_skid = 1'b1;
            end
         end
`endif
         default: w_state_d = EMPTY;
      endcase
      if (i_flush) begin
         w_state_d  = EMPTY;
         o_ld_main  = 1'b0;
         o_sel_skid = 1'b0;
         o_ld_skid  = 1'b0;
         o_kill     = 1'b1;
      end
   end

   // State register with registered status outputs derived from the next state.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state     <= EMPTY;
         r_out_valid <= 1'b0;
         r_occupancy <= 2'd0;
`ifdef PIPE_STAGE_SKID_EN
         r_in_ready  <= 1'b1;
`endif
      end else begin
         r_state     <= w_state_d;
         r_out_valid <= (w_state_d != EMPTY);
         r_occupancy <= state_occupancy(w_state_d);
`ifdef PIPE_STAGE_SKID_EN
         r_in_ready  <= (w_state_d != FULL);
`endif
      end
   end

   assign o_in_ready  = w_in_ready;
   assign o_out_valid = r_out_valid;
   assign o_occupancy = r_occupancy;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage with optional skid register (enable with PIPE_STAGE_SKID_EN).
// Holds payload/control in a main register that always drives out_*; the skid
// register catches one extra entry so in_ready can be registered.
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int unsigned        DATA_W    = PIPE_DATA_W,
   parameter int unsigned        CTRL_W    = PIPE_CTRL_W,
   parameter logic [CTRL_W-1:0]  KILL_MASK = '1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occupancy
);

   logic              w_ld_main;
   logic              w_sel_skid;
   logic              w_ld_skid;
   logic              w_kill;
   logic [DATA_W-1:0] w_src_data;
   logic [CTRL_W-1:0] w_src_ctrl;
   logic [DATA_W-1:0] r_main_data;
   logic [CTRL_W-1:0] r_main_ctrl;

   pipe_skid_ctrl u_ctrl (
      .CLK         (CLK),
      .RST         (RST),
      .i_flush     (flush),
      .i_in_valid  (in_valid),
      .i_out_ready (out_ready),
      .o_in_ready  (in_ready),
      .o_out_valid (out_valid),
      .o_occupancy (occupancy),
      .o_ld_main   (w_ld_main),
      .o_sel_skid  (w_sel_skid),
      .o_ld_skid   (w_ld_skid),
      .o_kill      (w_kill)
   );

`ifdef PIPE_STAGE_SKID_EN
   logic [DATA_W-1:0] r_skid_data;
   logic [CTRL_W-1:0] r_skid_ctrl;

   // Skid register captures the input while the main register is stalled.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_skid_data <= '0;
         r_skid_ctrl <= '0;
      end else if (w_ld_skid) begin
         r_skid_data <= in_data;
         r_skid_ctrl <= in_ctrl;
      end
   end

   assign w_src_data = w_sel_skid ? r_skid_data : in_data;
   assign w_src_ctrl = w_sel_skid ? r_skid_ctrl : in_ctrl;
`else
   logic w_unused_skid;
   assign w_unused_skid = w_sel_skid ^ w_ld_skid;
   assign w_src_data    = in_data;
   assign w_src_ctrl    = in_ctrl;
`endif

   // Main register; a flush kills the control bits but leaves the payload.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_main_data <= '0;
         r_main_ctrl <= '0;
      end else if (w_kill) begin
         r_main_ctrl <= r_main_ctrl & ~KILL_MASK;
      end else if (w_ld_main) begin
         r_main_data <= w_src_data;
         r_main_ctrl <= w_src_ctrl;
      end
   end

   assign out_data = r_main_data;
   assign out_ctrl = r_main_ctrl;

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter DATA_W, default 32: width of the datapath payload (operands, immediates).
REQ-002 Parameter CTRL_W, default 12: width of the packed control bundle (write enables, selects, ALU control, destination register).
REQ-003 Parameter KILL_MASK, default all-ones CTRL_W: control bits forced to 0 on a killed (flushed) entry.
REQ-004 CLK  input  1  clock; all state updates on rising edge only.
REQ-005 RST  input  1  reset; synchronous, active-high.
REQ-006 flush  input  1  discard every held entry.
REQ-007 in_valid  input  1  upstream stage presents an entry.
REQ-008 in_ready  output  1  stage accepts an entry this cycle.
REQ-009 in_data  input  DATA_W  upstream payload.
REQ-010 in_ctrl  input  CTRL_W  upstream control bundle.
REQ-011 out_valid  output  1  downstream entry valid.
REQ-012 out_ready  input  1  downstream consumes the entry this cycle.
REQ-013 out_data  output  DATA_W  held payload.
REQ-014 out_ctrl  output  CTRL_W  held control bundle.
REQ-015 occupancy  output  2  number of entries held (0..2).

Function
REQ-016 Transfer in: in_valid && in_ready at a rising edge; transfer out: out_valid && out_ready at a rising edge.
REQ-017 Latency: an entry accepted into an EMPTY stage SHALL appear on out_* exactly 1 cycle later.
REQ-018 FSM states EMPTY, BUSY (main register holds 1 entry), FULL (main + skid register hold 2).
REQ-019 EMPTY: transfer in -> BUSY; otherwise stay.
REQ-020 BUSY: in and out together -> BUSY (main reloads from input); in only -> FULL (input captured into skid); out only -> EMPTY; neither -> stay.
REQ-021 FULL: out -> BUSY (skid moves to main, same edge); otherwise stay; no transfer in is possible.
REQ-022 in_ready SHALL be registered, equal to 1 in EMPTY and BUSY, 0 in FULL; no combinational path from out_ready to in_ready.
REQ-023 out_valid SHALL be 1 exactly in BUSY and FULL; out_data/out_ctrl SHALL always come from the main register.
REQ-024 While out_valid && !out_ready, out_data/out_ctrl SHALL remain stable.
REQ-025 Entries SHALL leave in strict arrival order; none is dropped or duplicated.
REQ-026 flush SHALL force next state EMPTY, discarding main, skid and any simultaneous input; a simultaneous out transfer still completes.
REQ-027 On flush, out_ctrl SHALL take main-register ctrl AND NOT KILL_MASK; out_data holds its value.
REQ-028 occupancy SHALL be 0/1/2 for EMPTY/BUSY/FULL.

Reset
REQ-029 RST takes priority over flush and all transfers.
REQ-030 After a reset edge: state EMPTY, out_valid 0, in_ready 1, out_data 0, out_ctrl 0, occupancy 0, skid register 0.
REQ-031 Reset mid-operation (BUSY/FULL) SHALL drop all held entries with no output transfer in that cycle.

Configuration
REQ-032 Macro PIPE_STAGE_SKID_EN defined: behaviour as REQ-018..REQ-028 (2 entries, full throughput, registered in_ready).
REQ-033 Macro undefined: no skid register; FULL unreachable; in_ready = !out_valid || out_ready (combinational); occupancy max 1; all other requirements unchanged.

Structure
REQ-034 Package pipe_pkg SHALL hold the state enum typedef pipe_state_t (EMPTY, BUSY, FULL) and default-width constants PIPE_DATA_W=32, PIPE_CTRL_W=12.
REQ-035 One sub-module, pipe_skid_ctrl, SHALL contain the FSM, in_ready and register load enables; the parent holds the data/ctrl registers.

Verification
REQ-036 Reset, then in_valid=1, in_data=0x0000_00A5, out_ready=1 -> out_valid=1, out_data=0x0000_00A5 on the next cycle, occupancy=1.
REQ-037 Stream 0x1..0x8 back-to-back, out_ready=1 -> 8 outputs in order on 8 consecutive cycles, in_ready constantly 1.
REQ-038 Hold out_ready=0 and offer 0x10, 0x11, 0x12 -> 0x10, 0x11 accepted, in_ready=0 after 2nd, occupancy=2; release out_ready -> 0x10, 0x11, 0x12 emitted in order.
REQ-039 In FULL, assert flush with in_valid=1 -> next cycle out_valid=0, occupancy=0, in_ready=1, and out_ctrl masked by KILL_MASK; the flushed input never appears.
REQ-040 Assert RST in FULL with flush=1 and in_valid=1 -> all outputs at REQ-030 values next cycle.
REQ-041 Build without PIPE_STAGE_SKID_EN and rerun REQ-038 -> only 0x10 held, in_ready follows out_ready same cycle, order preserved.
